serial_fas_ctrl: RTL
====================

Name: serial_fas_ctrl

Overview:
Bit-serial add/subtract sequencer that drives one external fas full adder/subtractor cell and consumes its outputs.
- Latches two WIDTH-bit operands and an operation select.
- Presents one bit pair per clock (LSB first) to the fas cell, with the carry/borrow held in a flop.
- Shifts each sum bit into a result register.
- Reports the result, carry-out and signed overflow on a done pulse.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)
CNT_W, 4, counter width; must hold the value WIDTH (>= clog2(WIDTH+1))

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin operation; sampled only in IDLE
op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start
a_in  input  WIDTH  operand A; sampled with start
b_in  input  WIDTH  operand B; sampled with start
fas_a  output  1  bit of A to fas cell (a)
fas_b  output  1  bit of B to fas cell (b)
fas_cin  output  1  carry/borrow-in to fas cell (cin)
fas_s_op  output  1  operation select to fas cell (s_op)
fas_s  input  1  sum/difference bit from fas cell (s)
fas_cout  input  1  carry-out from fas cell (cout)
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when result is valid
result  output  WIDTH  final sum/difference; held until next start
cout_out  output  1  final carry-out (sub: 1 = no borrow)
overflow  output  1  signed two's-complement overflow

Behaviour:
- One clock domain, clk. rst is synchronous active-high; takes priority over all other inputs.
- fas cell contract (combinational):
  - s_op=0: s = a^b^cin, cout = maj(a,b,cin).
  - s_op=1: b is inverted internally, so s = a^~b^cin, cout = maj(a,~b,cin).
- Reset values:
  - state = IDLE.
  - busy, done, result, cout_out, overflow = 0.
  - Shift registers, counter and carry flop = 0, so fas_a, fas_b and fas_cin are 0.
  - fas_s_op = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 loads a_sh<=a_in, b_sh<=b_in, op_r<=op, carry<=op (the two's-complement +1 for subtract), cnt<=0, result shift reg <=0.
  - Next state RUN.
  - start=0: remain in IDLE.
- RUN (busy=1), each cycle:
  - fas_a=a_sh[0], fas_b=b_sh[0], fas_cin=carry, fas_s_op=op_r. These are driven from registers only.
  - On the clock edge: res_sh <= {fas_s, res_sh[WIDTH-1:1]}; carry <= fas_cout; a_sh and b_sh shift right 1; cnt++.
  - When cnt==WIDTH-2, capture prev_carry <= fas_cout. This is the carry into the MSB.
  - When cnt==WIDTH-1: result <= {fas_s, res_sh[WIDTH-1:1]}, cout_out <= fas_cout, overflow <= fas_cout ^ prev_carry; next state DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0; next state IDLE.
  - start is ignored in DONE.
- Latency: start sampled at edge N gives done high in the cycle following edge N+WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- start while busy or in DONE: ignored; operands and op are not resampled.
- result, cout_out and overflow hold their values after done until the next DONE update.
- Inputs a_in, b_in and op may change freely after the start cycle.
- The fas cell's propagation delay must settle within one clk period. Bench clk period >= 10 time units against the unit-delay fas.
- rst mid-RUN: next cycle state=IDLE, all outputs return to reset values, and the partial result is discarded.
- Wrap-around: the result is modulo 2^WIDTH.
  - Add: cout_out = unsigned carry.
  - Subtract: cout_out = NOT borrow.

Optional Feature:
ZERO_FLAG_EN
- Defined: adds output port zero (1 bit), reset 0, updated with result in the same edge. zero = (final result == 0).
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- rst=1 for 2 cycles, then idle: busy=0, done=0, result=0x00, fas_cin=0, fas_s_op=0.
- WIDTH=8, add 0x05+0x03 -> result=0x08, cout_out=0, overflow=0, done pulse exactly 9 cycles after start edge, busy high 8 cycles.
- add 0x7F+0x01 -> 0x80, overflow=1, cout_out=0; add 0xFF+0x01 -> 0x00, cout_out=1, overflow=0 (zero=1 with ZERO_FLAG_EN).
- sub 0x10-0x01 -> 0x0F, cout_out=1; sub 0x00-0x01 -> 0xFF, cout_out=0; sub 0x80-0x01 -> 0x7F, overflow=1.
- start re-asserted with new operands during RUN and in DONE -> ignored; result matches the first operation only.
- rst asserted at RUN cycle 4 -> next cycle IDLE, busy=0, no done pulse; a following start 0x02+0x02 -> 0x04 correctly.

Source files
------------

// File: rtl/serial_fas_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_fas_ctrl_if
// Description : Host-side command/result signals and fas-cell bit-serial
//               lanes for serial_fas_ctrl. ZERO_FLAG_EN adds the zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_fas_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             fas_a;
    logic             fas_b;
    logic             fas_cin;
    logic             fas_s_op;
    logic             fas_s;
    logic             fas_cout;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout_out;
    logic             overflow;
`ifdef ZERO_FLAG_EN
    logic             zero;

    modport master (
        output start, op, a_in, b_in, fas_s, fas_cout,
        input  fas_a, fas_b, fas_cin, fas_s_op,
        input  busy, done, result, cout_out, overflow, zero
    );

    modport slave (
        input  start, op, a_in, b_in, fas_s, fas_cout,
        output fas_a, fas_b, fas_cin, fas_s_op,
        output busy, done, result, cout_out, overflow, zero
    );
`else
    modport master (
        output start, op, a_in, b_in, fas_s, fas_cout,
        input  fas_a, fas_b, fas_cin, fas_s_op,
        input  busy, done, result, cout_out, overflow
    );

    modport slave (
        input  start, op, a_in, b_in, fas_s, fas_cout,
        output fas_a, fas_b, fas_cin, fas_s_op,
        output busy, done, result, cout_out, overflow
    );
`endif
endinterface
`default_nettype wire

// File: rtl/serial_fas_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_fas_ctrl
// Description : Bit-serial add/subtract sequencer driving one external fas
//               full adder/subtractor cell, LSB first. Optional macro
//               ZERO_FLAG_EN adds a registered zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_fas_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  wire               clk,
    input  wire               rst,
    serial_fas_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MSB = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_PRE = CNT_W'(WIDTH - 2);

    state_t             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   res_sh_q;
    logic [WIDTH-1:0]   res_sh_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               op_r_q;
    logic               carry_q;
    logic               prev_carry_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;
    logic               cout_q;
    logic               ovf_q;
`ifdef ZERO_FLAG_EN
    logic               zero_q;
`endif

    assign res_sh_d = {bus.fas_s, res_sh_q[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            res_sh_q     <= '0;
            cnt_q        <= '0;
            op_r_q       <= 1'b0;
            carry_q      <= 1'b0;
            prev_carry_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            cout_q       <= 1'b0;
            ovf_q        <= 1'b0;
`ifdef ZERO_FLAG_EN
            zero_q       <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        a_sh_q   <= bus.a_in;
                        b_sh_q   <= bus.b_in;
                        op_r_q   <= bus.op;
                        // Subtract seeds the carry with the two's-complement +1
                        carry_q  <= bus.op;
                        cnt_q    <= '0;
                        res_sh_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    res_sh_q <= res_sh_d;
                    carry_q  <= bus.fas_cout;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    cnt_q    <= cnt_q + c_CNT_ONE;
                    if (cnt_q == c_CNT_PRE) begin
                        prev_carry_q <= bus.fas_cout;
                    end
                    if (cnt_q == c_CNT_MSB) begin
                        result_q <= res_sh_d;
                        cout_q   <= bus.fas_cout;
                        // Carry into MSB differing from carry out of MSB means signed overflow
                        ovf_q    <= bus.fas_cout ^ prev_carry_q;
`ifdef ZERO_FLAG_EN
                        zero_q   <= (res_sh_d == '0);
`endif
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.fas_a    = a_sh_q[0];
    assign bus.fas_b    = b_sh_q[0];
    assign bus.fas_cin  = carry_q;
    assign bus.fas_s_op = op_r_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.cout_out = cout_q;
    assign bus.overflow = ovf_q;
`ifdef ZERO_FLAG_EN
    assign bus.zero     = zero_q;
`endif

endmodule
`default_nettype wire
